fm_meas_ctrl: RTL and testbench

FM_MEAS_CTRL -- requirements
Module: fm_meas_ctrl

---
 rtl/fm_meas_pkg.sv | 19 +
 rtl/fm_div_serial.sv | 55 +++++
 rtl/fm_meas_ctrl.sv | 134 +++++++++++++
 tb/tb_fm_meas_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fm_meas_pkg.sv
// rtl/fm_meas_pkg.sv - shared state encoding, code constants and saturation helper for fm_meas_ctrl
package fm_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_CALC,
    ST_DONE
  } state_t;

  localparam logic [9:0] MID_CODE = 10'd512;
  localparam logic [9:0] CODE_MAX = 10'd1023;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'd65535) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/fm_div_serial.sv
// rtl/fm_div_serial.sv - restoring 16/13-bit divider, one quotient bit per cycle
module fm_div_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [12:0] divisor,
  output logic        done,
  output logic [15:0] quotient
);

  logic [12:0] rem;
  logic [15:0] quo;
  logic [4:0]  bits_left;
  logic        run;
  logic [13:0] shifted;
  logic [12:0] diff;
  logic        fits;

  // Remainder stays below divisor, so the shifted partial remainder fits in 14 bits.
  always_comb begin
    shifted = {rem, quo[15]};
    fits    = (shifted >= {1'b0, divisor});
    diff    = 13'(shifted - {1'b0, divisor});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      quo       <= '0;
      bits_left <= '0;
      run       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem       <= '0;
        quo       <= dividend;
        bits_left <= 5'd16;
        run       <= 1'b1;
      end else if (run) begin
        rem       <= fits ? diff : shifted[12:0];
        quo       <= {quo[14:0], fits};
        bits_left <= bits_left - 5'd1;
        if (bits_left == 5'd1) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/fm_meas_ctrl.sv
// rtl/fm_meas_ctrl.sv - FM deviation / modulating-frequency / index measurement sequencer
module fm_meas_ctrl
  import fm_meas_pkg::*;
#(
  parameter int SETTLE_CYC = 256,
  parameter int GATE_CYC   = 320000,
  parameter int FREQ_SCALE = 100,
  parameter int KF         = 50,
  parameter int HYST       = 8
) (
  input  logic        clk_32m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  demod_in,
  input  logic        demod_valid,
  output logic        demod_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  mf,
  output logic [15:0] delta_f,
  output logic [12:0] mod_freq
);

  localparam int CNT_SPAN = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int CW = $clog2(CNT_SPAN + 32) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_CYC - 1);
  localparam logic [9:0] LO_TH = MID_CODE - 10'(HYST);
  localparam logic [9:0] HI_TH = MID_CODE + 10'(HYST);

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [9:0]    max_val, min_val;
  logic [7:0]    cross_cnt;
  logic          above;
  logic [8:0]    half_vpp;
  logic [31:0]   delta_full, modf_full;
  logic [15:0]   delta_c;
  logic [12:0]   modf_c;
  logic          div_start, div_done;
  logic [15:0]   div_q;
  logic [7:0]    mf_c;

  // max < min only when no valid sample arrived during the gate.
  always_comb begin
    half_vpp   = (max_val >= min_val) ? 9'((max_val - min_val) >> 1) : 9'd0;
    delta_full = 32'(half_vpp) * 32'(KF);
    modf_full  = 32'(cross_cnt) * 32'(FREQ_SCALE);
    delta_c    = sat16(delta_full);
    modf_c     = (modf_full > 32'd8191) ? 13'h1FFF : modf_full[12:0];
    mf_c       = (|div_q[15:8]) ? 8'hFF : div_q[7:0];
  end

  assign div_start = (state == ST_CALC) && (cnt == '0) && (modf_c != '0) && !abort;

  fm_div_serial u_div (
    .clk      (clk_32m),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (delta_c),
    .divisor  (modf_c),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start) next_state = ST_SETTLE;
      ST_SETTLE:  if (cnt == SETTLE_LAST) next_state = ST_MEASURE;
      ST_MEASURE: if (cnt == GATE_LAST) next_state = ST_CALC;
      ST_CALC: begin
        if (cnt == '0 && modf_c == '0) next_state = ST_DONE;
        else if (cnt != '0 && div_done) next_state = ST_DONE;
      end
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (abort && (state == ST_SETTLE || state == ST_MEASURE || state == ST_CALC))
      next_state = ST_IDLE;
  end

  assign demod_en = (state == ST_SETTLE) || (state == ST_MEASURE);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      max_val   <= '0;
      min_val   <= CODE_MAX;
      cross_cnt <= '0;
      above     <= 1'b0;
      err       <= 1'b0;
      mf        <= '0;
      delta_f   <= '0;
      mod_freq  <= '0;
    end else begin
      cnt <= (next_state != state || state == ST_IDLE) ? '0 : cnt + CW'(1);

      if (state == ST_SETTLE && next_state == ST_MEASURE) begin
        max_val   <= '0;
        min_val   <= CODE_MAX;
        cross_cnt <= '0;
        above     <= 1'b0;
      end else if (state == ST_MEASURE && demod_valid) begin
        if (demod_in > max_val) max_val <= demod_in;
        if (demod_in < min_val) min_val <= demod_in;
        if (demod_in <= LO_TH) begin
          above <= 1'b0;
        end else if (!above && demod_in >= HI_TH) begin
          above <= 1'b1;
          if (cross_cnt != 8'hFF) cross_cnt <= cross_cnt + 8'd1;
        end
      end

      // Results become visible together in the DONE cycle.
      if (state == ST_CALC && next_state == ST_DONE) begin
        delta_f  <= delta_c;
        mod_freq <= modf_c;
        mf       <= (modf_c == '0) ? 8'd0 : mf_c;
        err      <= (modf_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_fm_meas_ctrl.sv
// tb/tb_fm_meas_ctrl.sv - scoreboard bench for fm_meas_ctrl with a behavioural measurement model
module tb_fm_meas_ctrl;

  localparam int S    = 16;
  localparam int G    = 1500;
  localparam int FS   = 40;
  localparam int KFB  = 150;
  localparam int HY   = 8;

  logic        clk_32m = 1'b0;
  logic        rst_n, start, abort, demod_valid;
  logic [9:0]  demod_in;
  logic        demod_en, busy, done, err;
  logic [7:0]  mf;
  logic [15:0] delta_f;
  logic [12:0] mod_freq;

  typedef struct {
    int mf;
    int delta;
    int modf;
    int err;
  } res_t;

  res_t exp_q[$];
  res_t last_exp;
  int   n_vec  = 0;
  int   n_fail = 0;

  fm_meas_ctrl #(
    .SETTLE_CYC (S),
    .GATE_CYC   (G),
    .FREQ_SCALE (FS),
    .KF         (KFB),
    .HYST       (HY)
  ) dut (
    .clk_32m     (clk_32m),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .demod_in    (demod_in),
    .demod_valid (demod_valid),
    .demod_en    (demod_en),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mf          (mf),
    .delta_f     (delta_f),
    .mod_freq    (mod_freq)
  );

  always #5 clk_32m = ~clk_32m;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t predict(input bit have, input int mx, input int mn, input int nx);
    res_t r;
    int vpp, d, f;
    vpp = have ? (mx - mn) : 0;
    d = (vpp / 2) * KFB;
    if (d > 65535) d = 65535;
    f = ((nx > 255) ? 255 : nx) * FS;
    if (f > 8191) f = 8191;
    r.delta = d;
    r.modf  = f;
    if (f == 0) begin
      r.mf  = 0;
      r.err = 1;
    end else begin
      r.mf  = (d / f > 255) ? 255 : d / f;
      r.err = 0;
    end
    return r;
  endfunction

  function automatic int gen(input int kind, input int amp, input int per, input int i);
    int v;
    case (kind)
      0:       v = 512 + int'(real'(amp) * $sin(6.283185307179586 * real'(i) / real'(per)));
      1:       v = 512;
      2:       v = (i % 2 != 0) ? 512 + 6 : 512 - 6;
      3:       v = (i % 2 != 0) ? 1023 : 0;
      default: v = int'($urandom_range(0, 1023));
    endcase
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  always @(negedge clk_32m) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("mf", int'(mf), e.mf);
        chk("delta_f", int'(delta_f), e.delta);
        chk("mod_freq", int'(mod_freq), e.modf);
        chk("err", int'(err), e.err);
      end
    end
  end

  task automatic run_meas(input int kind, input int amp, input int per, input int vprob,
                          input int abort_at, input int rst_at);
    int mx, mn, nx, s;
    bit have, armed, v;
    res_t r;
    mx = 0; mn = 1023; nx = 0; have = 0; armed = 1;
    @(posedge clk_32m); #1;
    start = 1'b1;
    for (int i = 1; i <= S + G + 22; i++) begin
      @(posedge clk_32m); #1;
      if (abort_at != 0 && i == abort_at + 1) begin
        abort = 1'b0;
        start = 1'b0;
        chk("busy_after_abort", int'(busy), 0);
        chk("mf_kept", int'(mf), last_exp.mf);
        chk("delta_kept", int'(delta_f), last_exp.delta);
        chk("modf_kept", int'(mod_freq), last_exp.modf);
        chk("err_kept", int'(err), last_exp.err);
        return;
      end
      if (i == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mf", int'(mf), 0);
        chk("rst_delta", int'(delta_f), 0);
        chk("rst_modf", int'(mod_freq), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(posedge clk_32m);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk_32m);
        #1 chk("idle_after_rst", int'(busy), 0);
        last_exp = '{0, 0, 0, 0};
        return;
      end
      if (i > S + G + 1 && !busy) begin
        @(posedge clk_32m); #1;
        chk("pending_results", exp_q.size(), 0);
        return;
      end
      if (i == S + G + 22) begin
        chk("calc_bound_busy", int'(busy), 0);
        return;
      end
      start = (i == 5 || i == S + 10);
      abort = (i == abort_at);
      s = gen(kind, amp, per, i);
      v = ($urandom_range(1, 100) <= vprob);
      demod_in = 10'(s);
      demod_valid = v;
      if (i >= S + 1 && i <= S + G && v) begin
        have = 1;
        if (s > mx) mx = s;
        if (s < mn) mn = s;
        if (s <= 512 - HY) armed = 1;
        else if (armed && s >= 512 + HY) begin
          nx++;
          armed = 0;
        end
      end
      if (i == S + G && abort_at == 0 && rst_at == 0) begin
        r = predict(have, mx, mn, nx);
        exp_q.push_back(r);
        last_exp = r;
      end
      if (i == 1) begin
        chk("busy_settle", int'(busy), 1);
        chk("en_settle", int'(demod_en), 1);
      end
      if (i == S + G) chk("en_gate_end", int'(demod_en), 1);
      if (i == S + G + 1) begin
        chk("en_calc", int'(demod_en), 0);
        chk("busy_calc", int'(busy), 1);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    demod_in = 10'd512;
    demod_valid = 1'b0;
    last_exp = '{0, 0, 0, 0};
    repeat (3) @(posedge clk_32m);
    #1;
    chk("reset_mf", int'(mf), 0);
    chk("reset_delta", int'(delta_f), 0);
    chk("reset_modf", int'(mod_freq), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_en", int'(demod_en), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_32m);

    run_meas(0, 200, 150, 100, 0, 0);
    run_meas(1, 0, 1, 100, 0, 0);
    run_meas(2, 0, 1, 100, 0, 0);
    run_meas(0, 511, 4000, 100, 0, 0);
    run_meas(3, 0, 1, 100, 0, 0);
    run_meas(0, 511, 4000, 100, S + 300, 0);
    for (int k = 0; k < 3; k++) run_meas(4, 0, 1, 60, 0, 0);
    run_meas(0, 150, 100, 70, 8, 0);
    run_meas(0, 300, 200, 80, S + G + 4, 0);
    run_meas(0, 200, 150, 100, 0, S + G + 5);
    run_meas(0, 250, 120, 90, 0, 0);
    run_meas(2, 0, 1, 50, 0, 0);

    repeat (5) @(posedge clk_32m);
    #1 chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
